uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit stage directly downstream of the MCU frame sequencer. It accepts one byte per start_uart request and serialises it LSB-first as 8N1 on a single TX line. It returns a one-cycle tx_done pulse when the stop bit has finished. The MCU uses that pulse to step between its temperature and time frames.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
start_uart  input  1  transmit request (level); sampled in IDLE only.
send_data  input  8  byte to transmit; captured in the accept cycle.
tx  output  1  serial line, idle high.
tx_busy  output  1  high from the accept cycle until tx_done inclusive.
tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, bit index=0, shift register=0, armed=1.
- Reset mid-frame aborts at once: tx returns to 1 with no partial stop bit, and no tx_done is issued.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in). All outputs are registered.
- IDLE: tx=1. If start_uart=1 and armed=1, then in the same edge:
  - capture send_data into the shift register;
  - set tx_busy=1;
  - clear armed;
  - go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles. The first low cycle is the cycle after accept, so accept-to-falling-edge latency is 1 clk. Then go to DATA with bit index=0.
- DATA: tx=shift[bit index] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT cycles. Then in a single edge:
  - pulse tx_done=1 for exactly one cycle;
  - keep tx_busy=1 during that cycle;
  - return to IDLE.
  - tx_busy falls on the following cycle.
- Bit counter: counts 0..CLKS_PER_BIT-1. It wraps to 0 on each bit boundary and never free-runs in IDLE.
- Frame timing: a frame occupies 10*CLKS_PER_BIT cycles from the first low tx cycle to the end of the stop bit.
- Re-arm rule: armed is set whenever start_uart=0 is sampled in any state. A level held high across tx_done therefore does not retransmit. A new request needs start_uart to drop for at least one cycle.
  - Drop and re-raise both inside a frame: the request is accepted in the first IDLE cycle after tx_done.
- Changes to start_uart or send_data while busy are ignored; the data was latched at accept.
- Same edge as tx_done with start_uart=1 and armed=1: not accepted; accepted on the next cycle (IDLE). No back-to-back overlap is allowed.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit is inserted after bit 7, in the PARITY state.
  - tx = XOR of the 8 captured data bits, held for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles; tx_done moves out by one bit period.
- Undefined: the PARITY state and its logic are absent; the frame is 8N1.

Test Plan (CLKS_PER_BIT=4, feature off unless stated):
- Basic byte: reset low for 3 cycles, release; start_uart=1 with send_data=8'hA5 for one cycle.
  - tx waveform: 0 | 1,0,1,0,0,1,0,1 (LSB first) | 1, each level 4 cycles.
  - tx_done pulses once, 40 cycles after the first low cycle; tx_busy lasts 41 cycles.
- Held request: start_uart held at 1 across tx_done with send_data=8'h0F.
  - Exactly one frame is sent; tx stays 1 afterwards.
  - Dropping start_uart for 1 cycle and re-raising starts a second frame 1 cycle later.
- Data change while busy: send_data changes 8'h3C -> 8'hFF mid-frame.
  - Serialised bits still equal 8'h3C.
- Reset mid-frame: assert reset during data bit 3.
  - tx=1 asynchronously (before the next clk edge); tx_busy=0; no tx_done.
  - After release, a new 8'h55 frame is sent correctly.
- Two-frame MCU sequence: temperature 8'd200 (8'hC8) followed by 8'h0F, re-requested after each tx_done.
  - Two complete frames, with tx idle high for at least 1 cycle between them, and exactly two tx_done pulses.
- UART_TX_PARITY_EN defined: 8'h07 gives parity bit 1; 8'h03 gives parity bit 0.
  - Frame length is 44 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per start_uart request, LSB first, 8N1, one-cycle tx_done.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_uart,
   input  logic [7:0] send_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             armed_q, armed_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         armed_q   <= 1'b1;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         armed_q   <= armed_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Outputs are registered, so tx_d always carries the level of the bit that starts next cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      armed_d   = armed_q | ~start_uart;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            if (start_uart && armed_q) begin
               shift_d = send_data;
               busy_d  = 1'b1;
               armed_d = 1'b0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         START: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
               bit_idx_d = '0;
               tx_d      = shift_q[0];
               state_d   = DATA;
            end
         end

         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^shift_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[bit_idx_q + 3'd1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif

         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            // busy stays high through the tx_done cycle; IDLE drops it one cycle later
            if (bit_end) begin
               done_d  = 1'b1;
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at CLKS_PER_BIT=4; a negedge monitor decodes frames
// for the byte scoreboard while the driver checks every tx/tx_busy/tx_done cycle.
module tb_uart_tx_serializer;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int BITS  = PAR_EN ? 11 : 10;
   localparam int FRAME = BITS * CPB;
   localparam int NVEC  = 7;

   typedef struct {
      logic [7:0] d;
      logic [7:0] mid;
      logic       par;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       start_uart;
   logic [7:0] send_data;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];
   vec_t       vecs[NVEC];
   int         f0;
   int         dc0;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_uart (start_uart),
      .send_data  (send_data),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

   // Frame decoder: samples mid-bit on negedges, independent of the driver
   int         mon_cyc = -1;
   int         mon_frames = 0;
   int         done_cnt = 0;
   logic [7:0] mon_sr = '0;
   logic [7:0] mon_byte = '0;
   logic       mon_ok = 1'b0;

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (reset !== 1'b1) begin
         mon_cyc = -1;
      end else if (mon_cyc < 0) begin
         if (tx === 1'b0) begin
            mon_cyc = 0;
            mon_ok  = 1'b1;
         end
      end else begin
         mon_cyc++;
         if (mon_cyc == CPB / 2) mon_ok = mon_ok & (tx === 1'b0);
         for (int i = 0; i < 8; i++)
            if (mon_cyc == CPB * (i + 1) + CPB / 2) mon_sr[i] = tx;
         if (mon_cyc == CPB * (BITS - 1) + CPB / 2) begin
            mon_ok     = mon_ok & (tx === 1'b1);
            mon_byte   = mon_sr;
            mon_frames++;
            mon_cyc    = -1;
         end
      end
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkn(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = parity or stop, bit 10 = stop
   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par);
      return {1'b1, (PAR_EN ? par : 1'b1), d, 1'b0};
   endfunction

   task automatic drive_req(input logic [7:0] d);
      start_uart = 1'b1;
      send_data  = d;
      sb_q.push_back(d);
   endtask

   // Called right after the negedge on which the request was driven (or after the previous
   // tx_done cycle when chained); returns after the negedge of the tx_done cycle.
   task automatic check_frame(input logic [7:0] d, input logic par, input logic [7:0] mid,
                              input int drop_at, input int raise_at, input logic [7:0] next_d);
      logic [10:0] exp;
      logic [7:0]  b;
      int          frames0;
      exp     = make_frame(d, par);
      frames0 = mon_frames;
      for (int c = 0; c <= FRAME; c++) begin
         @(negedge clk);
         if (c < FRAME) begin
            check1($sformatf("tx %02h cyc %0d", d, c), tx, exp[c / CPB]);
            check1($sformatf("tx_busy %02h cyc %0d", d, c), tx_busy, 1'b1);
            check1($sformatf("tx_done early %02h cyc %0d", d, c), tx_done, 1'b0);
         end else begin
            check1($sformatf("tx_done pulse %02h", d), tx_done, 1'b1);
            check1($sformatf("tx_busy at done %02h", d), tx_busy, 1'b1);
            check1($sformatf("tx high at done %02h", d), tx, 1'b1);
            checkn($sformatf("frames decoded %02h", d), mon_frames, frames0 + 1);
            check1($sformatf("framing %02h", d), mon_ok, 1'b1);
            if (sb_q.size() != 0) begin
               b = sb_q.pop_front();
               checkn("rx byte", int'(mon_byte), int'(b));
            end else begin
               n_vec++;
               n_err++;
               $display("FAIL scoreboard: got byte %02h with no expected entry", mon_byte);
            end
         end
         if (c == drop_at) start_uart = 1'b0;
         if (c == 10) send_data = mid;
         if (c == raise_at) begin
            start_uart = 1'b1;
            send_data  = next_d;
            sb_q.push_back(next_d);
         end
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check1({name, " tx"}, tx, 1'b1);
      check1({name, " tx_busy"}, tx_busy, 1'b0);
      check1({name, " tx_done"}, tx_done, 1'b0);
   endtask

   initial begin
      vecs[0] = '{d: 8'hA5, mid: 8'hA5, par: 1'b0};
      vecs[1] = '{d: 8'h3C, mid: 8'hFF, par: 1'b0};
      vecs[2] = '{d: 8'h00, mid: 8'hFF, par: 1'b0};
      vecs[3] = '{d: 8'hFF, mid: 8'h00, par: 1'b0};
      vecs[4] = '{d: 8'h07, mid: 8'h07, par: 1'b1};
      vecs[5] = '{d: 8'h03, mid: 8'h03, par: 1'b0};
      vecs[6] = '{d: 8'h80, mid: 8'h7F, par: 1'b1};

      reset      = 1'b1;
      start_uart = 1'b0;
      send_data  = 8'h00;
      #1 reset = 1'b0;
      #1;
      check1("reset tx", tx, 1'b1);
      check1("reset tx_busy", tx_busy, 1'b0);
      check1("reset tx_done", tx_done, 1'b0);
      repeat (3) @(negedge clk);
      check1("in reset tx", tx, 1'b1);
      check1("in reset tx_busy", tx_busy, 1'b0);
      reset = 1'b1;
      check_idle("after release");

      for (int i = 0; i < NVEC; i++) begin
         drive_req(vecs[i].d);
         check_frame(vecs[i].d, vecs[i].par, vecs[i].mid, 0, -1, 8'h00);
         check_idle("post frame");
      end

      // Held request: one frame only, then a one-cycle drop re-arms
      drive_req(8'h0F);
      check_frame(8'h0F, 1'b0, 8'h0F, -1, -1, 8'h00);
      for (int k = 0; k < 6; k++) check_idle("held no retransmit");
      start_uart = 1'b0;
      @(negedge clk);
      drive_req(8'h5A);
      check_frame(8'h5A, 1'b0, 8'h5A, 0, -1, 8'h00);
      check_idle("after rearm frame");

      // Reset during data bit 3 aborts without tx_done
      dc0 = done_cnt;
      f0  = mon_frames;
      drive_req(8'h96);
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         if (c == 0) start_uart = 1'b0;
      end
      check1("bit3 of 96 before reset", tx, 1'b0);
      check1("busy before reset", tx_busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      check1("async reset tx", tx, 1'b1);
      check1("async reset tx_busy", tx_busy, 1'b0);
      check1("async reset tx_done", tx_done, 1'b0);
      void'(sb_q.pop_back());
      repeat (2) begin
         @(negedge clk);
         check1("reset held tx_done", tx_done, 1'b0);
         check1("reset held tx", tx, 1'b1);
      end
      reset = 1'b1;
      check_idle("after abort");
      checkn("aborted frame not decoded", mon_frames, f0);
      checkn("no tx_done on abort", done_cnt, dc0);
      drive_req(8'h55);
      check_frame(8'h55, 1'b0, 8'h55, 0, -1, 8'h00);
      check_idle("after 55 frame");

      // MCU sequence: temperature then time byte, re-requested inside the first frame
      dc0 = done_cnt;
      drive_req(8'hC8);
      check_frame(8'hC8, 1'b1, 8'hC8, 0, 20, 8'h0F);
      check_frame(8'h0F, 1'b0, 8'h0F, 0, -1, 8'h00);
      check_idle("after MCU pair");
      checkn("MCU pair tx_done count", done_cnt - dc0, 2);

      checkn("scoreboard drained", sb_q.size(), 0);
      checkn("total tx_done pulses", done_cnt, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
